// File: rtl/tx_fc_arbiter.sv
// tx_fc_arbiter: credit-aware arbiter choosing among Posted, Non-Posted and
// Completion TLP sources. A source can win only when it has enough header and
// data credits. Each win sends one consume pulse to flow control, and the grant
// is held until the datapath signals xfer_done.
// Optional build macro: TX_ARB_P_STRICT_PRIORITY_EN. When it is defined, an
// eligible Posted source always wins. Otherwise all three sources share one
// round-robin.
module tx_fc_arbiter #(
  parameter int FC_HDR_WIDTH  = 12,
  parameter int FC_DATA_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          arst,
  input  logic [2:0]                    req_valid,
  input  logic [2:0]                    req_has_data,
  input  logic [2:0][9:0]               req_len,
  input  logic [2:0][FC_HDR_WIDTH-1:0]  hdr_avail,
  input  logic [2:0][FC_DATA_WIDTH-1:0] data_avail,
  input  logic                          xfer_done,
  output logic [2:0]                    grant,
  output logic                          fc_consume_valid,
  output logic [1:0]                    fc_consume_type,
  output logic [8:0]                    fc_consume_data,
  output logic                          busy
);

  // Credit comparison width: wide enough for both the credit count and the 9-bit need.
  localparam int CMPW = (FC_DATA_WIDTH > 9) ? FC_DATA_WIDTH : 9;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state_reg, state_next;
  logic [2:0] grant_reg, grant_next;
  logic       busy_reg, busy_next;
  logic       cv_reg, cv_next;
  logic [1:0] ctype_reg, ctype_next;
  logic [8:0] cdata_reg, cdata_next;
  logic [1:0] rr_reg, rr_next;
  logic [1:0] winner_reg, winner_next;

  logic [2:0]      eligible;
  logic [2:0][8:0] need;
  logic [2:0]      cand;
  logic            pick_valid;
  logic [1:0]      pick_idx;

  // Compute each source's data-credit need and eligibility. A length of 0 means 1024 DW.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_src
      logic [10:0] len_ext;
      logic [10:0] len_round;
      assign len_ext   = (req_len[gi] == 10'd0) ? 11'd1024 : {1'b0, req_len[gi]};
      assign len_round = len_ext + 11'd3;
      assign need[gi]  = req_has_data[gi] ? len_round[10:2] : 9'd0;
      assign eligible[gi] = req_valid[gi] && (hdr_avail[gi] != '0) &&
                            (CMPW'(data_avail[gi]) >= CMPW'(need[gi]));
    end
  endgenerate

  // Select the winner: the first candidate found when scanning from rr, with wrap-around.
  always_comb begin
    cand       = eligible;
`ifdef TX_ARB_P_STRICT_PRIORITY_EN
    // An eligible P source takes the slot. Otherwise NP and CPL share the round-robin.
    if (eligible[0]) cand = 3'b001;
    else             cand = eligible & 3'b110;
`endif
    pick_valid = |cand;
    pick_idx   = 2'd0;
    for (int k = 2; k >= 0; k--) begin
      // Scan in reverse so the entry closest to rr is written last.
      if (cand[(int'(rr_reg) + k) % 3]) pick_idx = 2'((int'(rr_reg) + k) % 3);
    end
  end

  // Next-state and registered-output logic. The consume fields default to zero
  // every cycle, so the consume pulse lasts exactly one cycle.
  always_comb begin
    state_next  = state_reg;
    grant_next  = grant_reg;
    busy_next   = busy_reg;
    cv_next     = 1'b0;
    ctype_next  = 2'd0;
    cdata_next  = 9'd0;
    rr_next     = rr_reg;
    winner_next = winner_reg;
    case (state_reg)
      IDLE: begin
        grant_next = 3'b000;
        busy_next  = 1'b0;
        if (pick_valid) begin
          grant_next  = 3'b001 << pick_idx;
          busy_next   = 1'b1;
          cv_next     = 1'b1;
          ctype_next  = pick_idx;
          cdata_next  = need[pick_idx];
          winner_next = pick_idx;
          state_next  = BUSY;
        end
      end
      BUSY: begin
        if (xfer_done) begin
          grant_next = 3'b000;
          busy_next  = 1'b0;
          state_next = IDLE;
`ifdef TX_ARB_P_STRICT_PRIORITY_EN
          if (winner_reg != 2'd0)
            rr_next = (winner_reg == 2'd2) ? 2'd0 : winner_reg + 2'd1;
`else
          rr_next = (winner_reg == 2'd2) ? 2'd0 : winner_reg + 2'd1;
`endif
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register with asynchronous reset. Reset drops any outstanding grant
  // and does not replay the consume pulse.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_reg  <= IDLE;
      grant_reg  <= 3'b000;
      busy_reg   <= 1'b0;
      cv_reg     <= 1'b0;
      ctype_reg  <= 2'd0;
      cdata_reg  <= 9'd0;
      rr_reg     <= 2'd0;
      winner_reg <= 2'd0;
    end else begin
      state_reg  <= state_next;
      grant_reg  <= grant_next;
      busy_reg   <= busy_next;
      cv_reg     <= cv_next;
      ctype_reg  <= ctype_next;
      cdata_reg  <= cdata_next;
      rr_reg     <= rr_next;
      winner_reg <= winner_next;
    end
  end

  assign grant            = grant_reg;
  assign busy             = busy_reg;
  assign fc_consume_valid = cv_reg;
  assign fc_consume_type  = ctype_reg;
  assign fc_consume_data  = cdata_reg;

endmodule

// File: tb/tb_tx_fc_arbiter.sv
// Testbench for tx_fc_arbiter. A directed sequence runs first, then random
// traffic. Every cycle the DUT outputs are compared with a transaction-level
// reference model.
module tb_tx_fc_arbiter;

`ifdef TX_ARB_P_STRICT_PRIORITY_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              arst = 1'b1;
  logic [2:0]        req_valid = '0;
  logic [2:0]        req_has_data = '0;
  logic [2:0][9:0]   req_len = '0;
  logic [2:0][11:0]  hdr_avail = '0;
  logic [2:0][15:0]  data_avail = '0;
  logic              xfer_done = 1'b0;
  logic [2:0]        grant;
  logic              fc_consume_valid;
  logic [1:0]        fc_consume_type;
  logic [8:0]        fc_consume_data;
  logic              busy;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state.
  int m_busy, m_grant, m_cv, m_ct, m_cd, m_rr, m_win;

  tx_fc_arbiter #(.FC_HDR_WIDTH(12), .FC_DATA_WIDTH(16)) dut (
    .clk(clk), .arst(arst), .req_valid(req_valid), .req_has_data(req_has_data),
    .req_len(req_len), .hdr_avail(hdr_avail), .data_avail(data_avail),
    .xfer_done(xfer_done), .grant(grant), .fc_consume_valid(fc_consume_valid),
    .fc_consume_type(fc_consume_type), .fc_consume_data(fc_consume_data), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int need_of(int i);
    int len;
    if (!req_has_data[i]) return 0;
    len = (req_len[i] == 0) ? 1024 : int'(req_len[i]);
    return (len + 3) / 4;
  endfunction

  function automatic bit elig(int i);
    return req_valid[i] && (int'(hdr_avail[i]) >= 1) && (int'(data_avail[i]) >= need_of(i));
  endfunction

  task automatic model_reset();
    m_busy = 0; m_grant = 0; m_cv = 0; m_ct = 0; m_cd = 0; m_rr = 0; m_win = 0;
  endtask

  // One rising edge of the reference model.
  task automatic model_edge();
    int w;
    m_cv = 0; m_ct = 0; m_cd = 0;
    if (m_busy != 0) begin
      if (xfer_done) begin
        m_busy = 0; m_grant = 0;
        if (!(STRICT && m_win == 0)) m_rr = (m_win + 1) % 3;
      end
    end else begin
      w = -1;
      if (STRICT && elig(0)) w = 0;
      for (int k = 0; k < 3; k++) begin
        int idx;
        idx = (m_rr + k) % 3;
        if (w < 0 && elig(idx) && !(STRICT && idx == 0)) w = idx;
        if (w < 0 && !STRICT && elig(idx)) w = idx;
      end
      if (w >= 0) begin
        m_busy = 1; m_grant = 1 << w; m_cv = 1; m_ct = w; m_cd = need_of(w); m_win = w;
      end
    end
  endtask

  task automatic check(input string name, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".grant"}, 16'(grant), 16'(m_grant));
    check({tag, ".busy"},  16'(busy),  16'(m_busy));
    check({tag, ".cv"},    16'(fc_consume_valid), 16'(m_cv));
    check({tag, ".ctype"}, 16'(fc_consume_type),  16'(m_ct));
    check({tag, ".cdata"}, 16'(fc_consume_data),  16'(m_cd));
  endtask

  // Advance one clock, update the model, then compare at the falling edge.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(tag);
    $display("cycle t=%0t %s: grant=%b busy=%b cv=%b type=%0d data=%0d", $time, tag,
             grant, busy, fc_consume_valid, fc_consume_type, fc_consume_data);
  endtask

  // Asynchronous reset pulse at the current falling edge. Outputs must clear without a clock edge.
  task automatic pulse_reset(input string tag);
    arst = 1'b1;
    model_reset();
    #1;
    check_all(tag);
    arst = 1'b0;
  endtask

  initial begin
    logic [2:0] order_exp [4];
    model_reset();
    #2;
    check_all("reset");
    @(negedge clk);
    arst = 1'b0;

    // Single P request: len 10 needs 3 data credits.
    req_valid = 3'b001; req_has_data = 3'b001; req_len[0] = 10'd10;
    hdr_avail[0] = 12'd30; data_avail[0] = 16'd1000;
    step("p_single");
    check("p_single.cdata_const", 16'(fc_consume_data), 16'd3);
    step("p_hold1"); step("p_hold2"); step("p_hold3");
    xfer_done = 1'b1;
    step("p_done");
    xfer_done = 1'b0; req_valid = '0;
    step("p_idle");

    // All three sources eligible; the round-robin order starts from P after reset.
    pulse_reset("rst2");
    req_valid = 3'b111; req_has_data = 3'b000;
    hdr_avail = {12'd5, 12'd5, 12'd5};
    if (STRICT) order_exp = '{3'b001, 3'b001, 3'b001, 3'b001};
    else        order_exp = '{3'b001, 3'b010, 3'b100, 3'b001};
    for (int t = 0; t < 4; t++) begin
      step("rr_grant");
      check("rr_order", 16'(grant), 16'(order_exp[t]));
      xfer_done = 1'b1;
      step("rr_done");
      xfer_done = 1'b0;
    end
    req_valid = '0;
    step("rr_idle");

    // Length 0 means 1024 DW, so 256 data credits are needed.
    req_valid = 3'b001; req_has_data = 3'b001; req_len[0] = 10'd0; data_avail[0] = 16'd255;
    step("len0_short"); step("len0_short2");
    data_avail[0] = 16'd256;
    step("len0_grant");
    check("len0.cdata_const", 16'(fc_consume_data), 16'd256);
    xfer_done = 1'b1; step("len0_done"); xfer_done = 1'b0; req_valid = '0;
    step("len0_idle");

    // NP has no header credit, so CPL wins. NP wins once its credit arrives.
    req_valid = 3'b110; req_has_data = 3'b000; hdr_avail[1] = 12'd0; hdr_avail[2] = 12'd4;
    step("hdr_skip");
    check("hdr_skip.cpl", 16'(grant), 16'd4);
    xfer_done = 1'b1; step("hdr_done"); xfer_done = 1'b0;
    req_valid = 3'b010; hdr_avail[1] = 12'd1;
    step("hdr_np");
    check("hdr_np.grant", 16'(grant), 16'd2);

    // Asynchronous reset in the middle of a transfer.
    step("rst_busy");
    @(negedge clk);
    pulse_reset("rst_mid");
    req_valid = 3'b111;
    step("rst_fresh");
    check("rst_fresh.p", 16'(grant), 16'd1);
    step("rst_nopulse");

    // Credits drop to zero while busy: the grant is held and no new pulse is issued.
    hdr_avail = '0; data_avail = '0;
    step("drop1"); step("drop2"); step("drop3");
    xfer_done = 1'b1; step("drop_done"); xfer_done = 1'b0;
    step("drop_idle");

    // Random traffic with occasional asynchronous resets.
    for (int n = 0; n < 1500; n++) begin
      req_valid = 3'($urandom); req_has_data = 3'($urandom);
      for (int i = 0; i < 3; i++) begin
        req_len[i]    = ($urandom_range(0, 7) == 0) ? 10'd0 : 10'($urandom);
        hdr_avail[i]  = 12'($urandom_range(0, 2));
        data_avail[i] = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 300));
      end
      xfer_done = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 199) == 0) pulse_reset("rnd_rst");
      step("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tx_fc_arbiter.md
# tx_fc_arbiter

Credit-aware transmit arbiter for the TL Tx path. It picks one of three TLP sources per transfer: Posted (P), Non-Posted (NP) and Completion (CPL). A source may win only if it holds valid and the Tx flow-control block reports enough header and data credits for its TLP. On each win the block issues a one-cycle consume command to the flow-control block. It then holds the grant until the datapath signals end of transfer.

## Interface
Parameters:
- FC_HDR_WIDTH, 12, width of header credit counts
- FC_DATA_WIDTH, 16, width of data credit counts

Ports (index 0 = P, 1 = NP, 2 = CPL for all 3-entry vectors and arrays):
- clk  in  1  single clock; all state on rising edge
- arst  in  1  reset, asynchronous, active-high
- req_valid  in  3  source requests a TLP slot
- req_has_data  in  3  TLP carries payload
- req_len  in  3x10  payload length in DW; 0 encodes 1024 DW
- hdr_avail  in  3xFC_HDR_WIDTH  header credits available per type
- data_avail  in  3xFC_DATA_WIDTH  data credits available per type
- xfer_done  in  1  datapath finished the granted TLP
- grant  out  3  one-hot grant, held for the whole transfer
- fc_consume_valid  out  1  one-cycle pulse: consume credits
- fc_consume_type  out  2  0=P, 1=NP, 2=CPL; 3 never driven
- fc_consume_data  out  9  data credits consumed (0..256)
- busy  out  1  a grant is outstanding

## Operation
- Credits needed per TLP:
  - Header: always 1.
  - Data: 0 if req_has_data=0, otherwise ceil(L/4) with L = req_len (0 treated as 1024).
  - Data credit result is 9 bits; 1024 DW gives 256.
- Eligibility of source i:
  - req_valid[i]=1, and
  - hdr_avail[i] >= 1, and
  - data_avail[i] >= needed data. Comparisons are unsigned, with the credit count zero-extended to the wider operand.
- FSM, two states:
  - IDLE:
    - If any source is eligible, choose the winner by round-robin starting at pointer rr (2 bits, values 0..2).
    - Register grant = onehot(winner), pulse fc_consume_valid with type/data of the winner, set busy, go to BUSY.
    - If no source is eligible, stay in IDLE and keep all outputs at 0.
  - BUSY:
    - grant and busy hold; fc_consume_valid = 0.
    - On xfer_done=1: clear grant and busy, set rr = winner+1 (2 wraps to 0), go to IDLE.
    - xfer_done is ignored in IDLE.
- The granted source must hold req_valid, req_has_data and req_len stable until xfer_done.
  - If req_valid drops early, the block still waits for xfer_done.
  - Credits are never refunded.
- Credit inputs only gate arbitration. Credit changes while in BUSY have no effect on the current grant.
- fc_consume_type and fc_consume_data are valid only while fc_consume_valid=1. They read 0 otherwise.

## Timing
- Reset values: grant=0, busy=0, fc_consume_valid=0, fc_consume_type=0, fc_consume_data=0, rr=0, FSM=IDLE.
- arst forces the reset values asynchronously, including mid-transfer; no consume pulse is replayed after reset.
- Arbitration latency: eligible at edge N in IDLE → grant, busy and fc_consume_valid high after edge N (visible in cycle N+1).
- Release: xfer_done sampled at edge M in BUSY → grant=0 and busy=0 after edge M. The earliest next grant is after edge M+1 (one idle cycle between transfers).
- Minimum grant length is one cycle: xfer_done may be high in the first BUSY cycle.
- Exactly one fc_consume_valid pulse per grant, coincident with the first grant cycle.
- Throughput: at most one TLP per 2 cycles plus transfer length.

## Configuration
- TX_ARB_P_STRICT_PRIORITY_EN
  - Defined: an eligible P source always wins. NP and CPL round-robin between themselves. rr updates only when NP or CPL wins.
  - Undefined: plain three-way round-robin as described in Operation.

## Test plan
- Reset then single P request (req_has_data=1, req_len=10, hdr_avail[0]=30, data_avail[0]=1000) → grant=001 the next cycle, one pulse with fc_consume_type=0, fc_consume_data=3. xfer_done 4 cycles later → grant=000 one cycle after.
- P, NP and CPL all eligible continuously, xfer_done one cycle after each grant → grant order P, NP, CPL, P (macro undefined). With the macro defined → P on every transfer.
- req_len=0 with data → fc_consume_data=256. With data_avail=255 → no grant. Raise data_avail to 256 → grant the next cycle.
- hdr_avail[1]=0 with NP valid, CPL valid and rr pointing at NP → CPL granted and NP skipped. NP granted once hdr_avail[1]=1.
- arst asserted during BUSY → grant, busy and fc_consume outputs 0 immediately. After release, a fresh request gets a grant with exactly one new consume pulse, and rr restarts at P.
- Credits drop to 0 during BUSY → grant held until xfer_done, with no extra consume pulse.
